// File: rtl/mresp_pkg.sv
// Shared constants, packed-bus field positions and FSM state type for the mresp_sram responder.
package mresp_pkg;

  localparam int unsigned FWD_W = 69;
  localparam int unsigned RET_W = 33;

  // Forward bus: {wdata, wstrb, addr, valid}
  localparam int unsigned VALID_BIT = 0;
  localparam int unsigned ADDR_LSB  = 1;
  localparam int unsigned ADDR_MSB  = 32;
  localparam int unsigned WSTRB_LSB = 33;
  localparam int unsigned WSTRB_MSB = 36;
  localparam int unsigned WDATA_LSB = 37;
  localparam int unsigned WDATA_MSB = 68;

  // Return bus: {ready, rdata}
  localparam int unsigned RDATA_LSB = 0;
  localparam int unsigned RDATA_MSB = 31;
  localparam int unsigned READY_BIT = 32;

  localparam logic [31:0] BERR_DATA = 32'hBADB_AD00;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } mresp_state_e;

endpackage

// File: rtl/mresp_ram.sv
// DEPTH x 32 synchronous scratch RAM with per-byte write enables and a registered read port.
module mresp_ram
  import mresp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mresp_sram.sv
// Memory-side scratch SRAM responder on the packed PicoRV32-style bus; return bus is zero unless
// acking. Optional sticky out-of-range error flag enabled by defining MRESP_BERR_EN.
module mresp_sram
  import mresp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WIN_AW      = 10,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FWD_W-1:0] mem_packed_fwd,
  output logic [RET_W-1:0] mem_packed_ret
`ifdef MRESP_BERR_EN
  ,
  output logic             berr,
  input  logic             berr_clr
`endif
);

  localparam int unsigned RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TAG_LSB = WIN_AW + 2;

`ifdef MRESP_BERR_EN
  localparam logic [31:0] OOR_DATA = BERR_DATA;
`else
  localparam logic [31:0] OOR_DATA = 32'h0;
`endif

  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        sel;
  logic        unused_addr;

  assign req_valid   = mem_packed_fwd[VALID_BIT];
  assign req_addr    = mem_packed_fwd[ADDR_MSB:ADDR_LSB];
  assign req_wstrb   = mem_packed_fwd[WSTRB_MSB:WSTRB_LSB];
  assign req_wdata   = mem_packed_fwd[WDATA_MSB:WDATA_LSB];
  assign unused_addr = ^req_addr[1:0];
  assign sel         = req_valid && (req_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  mresp_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WIN_AW-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  // WAIT always lasts at least one cycle: it is the RAM access cycle, closed by the ACK edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          idx_d   = req_addr[TAG_LSB-1:2];
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = 4'(WAIT_STATES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  logic        ack_edge;
  logic        in_range;
  logic        is_write;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign ack_edge = (state_q == StWait) && (cnt_q == 4'd0);
  assign in_range = 32'(idx_q) < DEPTH;
  assign is_write = |wstrb_q;
  assign ram_we   = (ack_edge && in_range) ? wstrb_q : 4'h0;
  assign ram_re   = ack_edge && in_range && !is_write;

  mresp_ram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (idx_q[RAM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    mem_packed_ret = '0;
    if (state_q == StAck) begin
      mem_packed_ret[READY_BIT] = 1'b1;
      if (!in_range) begin
        mem_packed_ret[RDATA_MSB:RDATA_LSB] = OOR_DATA;
      end else if (!is_write) begin
        mem_packed_ret[RDATA_MSB:RDATA_LSB] = ram_rdata;
      end
    end
  end

`ifdef MRESP_BERR_EN
  logic berr_q, berr_d;

  // A new error on the same edge as a clear must not be lost.
  always_comb begin
    berr_d = berr_q;
    if (berr_clr) begin
      berr_d = 1'b0;
    end
    if (ack_edge && !in_range) begin
      berr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      berr_q <= 1'b0;
    end else begin
      berr_q <= berr_d;
    end
  end

  assign berr = berr_q;
`endif

endmodule
